// File: rtl/switch_sweep_ctrl.sv
// Walks a 4-bit switch pattern 0..15 into a datapath, captures led_in after SETTLE_CYCLES, sums results.
// Capture strobe SETTLE_CYCLES+2 clocks after start; advance is timed (auto) or on a debounced step press, with no backpressure.
module switch_sweep_ctrl #(
    parameter int SETTLE_CYCLES   = 2,
    parameter int DWELL_CYCLES    = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       auto_mode,
    input  logic       step,
    input  logic [4:0] led_in,
    output logic [3:0] sw_out,
    output logic       cap_valid,
    output logic [3:0] cap_sw,
    output logic [4:0] cap_led,
    output logic       busy,
    output logic       done,
    output logic [8:0] sum_out
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 0)   ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int DWELL_W  = (DWELL_CYCLES > 2)    ? $clog2(DWELL_CYCLES)      : 1;
    localparam int DEB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES)   : 1;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CAPTURE,
        WAIT,
        DONE
    } state_t;

    state_t              state_q;
    logic [3:0]          idx_q;
    logic [3:0]          sw_q;
    logic                cap_valid_q;
    logic [3:0]          cap_sw_q;
    logic [4:0]          cap_led_q;
    logic                busy_q;
    logic                done_q;
    logic [8:0]          sum_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [DWELL_W-1:0]  dwell_q;

    logic                step_s1_q;
    logic                step_s2_q;
    logic                deb_q;
    logic                deb_prev_q;
    logic [DEB_W-1:0]    deb_cnt_q;
    logic                step_pulse;

    // Synchronized level must disagree with the accepted level for DEBOUNCE_CYCLES clocks in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_s1_q  <= 1'b0;
            step_s2_q  <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
        end else begin
            step_s1_q  <= step;
            step_s2_q  <= step_s1_q;
            deb_prev_q <= deb_q;
            if (step_s2_q == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_q     <= step_s2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end

    assign step_pulse = deb_q & ~deb_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            sw_q        <= 4'd0;
            cap_valid_q <= 1'b0;
            cap_sw_q    <= 4'd0;
            cap_led_q   <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_q       <= 9'd0;
            settle_q    <= '0;
            dwell_q     <= '0;
        end else begin
            cap_valid_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                idx_q   <= 4'd0;
                sw_q    <= 4'd0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                dwell_q <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            state_q <= DRIVE;
                            idx_q   <= 4'd0;
                            sum_q   <= 9'd0;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                    DRIVE: begin
                        sw_q     <= idx_q;
                        settle_q <= SETTLE_W'(SETTLE_CYCLES);
                        state_q  <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_q <= SETTLE_W'(1)) begin
                            state_q <= CAPTURE;
                        end else begin
                            settle_q <= settle_q - 1'b1;
                        end
                    end
                    CAPTURE: begin
                        cap_valid_q <= 1'b1;
                        cap_sw_q    <= idx_q;
                        cap_led_q   <= led_in;
                        sum_q       <= sum_q + {4'd0, led_in};
                        dwell_q     <= '0;
                        if (idx_q == 4'd15) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        // Dwell only accumulates while auto_mode is high, so a 0->1 change counts from zero.
                        if (!auto_mode) begin
                            dwell_q <= '0;
                            if (step_pulse) begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= DRIVE;
                            end
                        end else if (dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
                            dwell_q <= '0;
                            idx_q   <= idx_q + 1'b1;
                            state_q <= DRIVE;
                        end else begin
                            dwell_q <= dwell_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sw_out    = sw_q;
    assign cap_valid = cap_valid_q;
    assign cap_sw    = cap_sw_q;
    assign cap_led   = cap_led_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sum_out   = sum_q;

endmodule
